// File: rtl/stream_pkg.sv
// Shared definitions for stream_mux: lock FSM state encoding and the
// channel-index width helper.
package stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr, wrapping modulo channels.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int  channels = 4,
  localparam int sel_w    = clog2(channels)
) (
  input  logic [channels-1:0] req,
  input  logic [sel_w-1:0]    ptr,
  output logic [channels-1:0] grant,
  output logic [sel_w-1:0]    grant_idx
);

  logic [sel_w:0]   sum  [channels];
  logic [sel_w-1:0] cand [channels];
  logic             found;

  // One extra bit keeps ptr+offset exact so non-power-of-two counts wrap correctly.
  generate
    for (genvar gi = 0; gi < channels; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, ptr} + (sel_w+1)'(gi);
      assign cand[gi] = (sum[gi] >= (sel_w+1)'(channels))
                        ? sel_w'(sum[gi] - (sel_w+1)'(channels))
                        : sel_w'(sum[gi]);
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < channels; k++) begin
      if (!found && req[cand[k]]) begin
        found           = 1'b1;
        grant[cand[k]]  = 1'b1;
        grant_idx       = cand[k];
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel round-robin stream multiplexer with a registered output stage.
// Define STREAM_MUX_LOCK_EN to hold the grant for a whole packet (until in_last).
module stream_mux
  import stream_pkg::*;
#(
  parameter int  width    = 8,
  parameter int  channels = 4,
  localparam int sel_w    = clog2(channels)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [channels*width-1:0] in_data,
  input  logic [channels-1:0]       in_valid,
  input  logic [channels-1:0]       in_last,
  output logic [channels-1:0]       in_ready,
  output logic [width-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [sel_w-1:0]          out_sel,
  input  logic                      out_ready
);

  logic [width-1:0]    ch_data [channels];
  logic [channels-1:0] arb_grant, grant;
  logic [sel_w-1:0]    arb_idx, grant_idx, ptr_inc;
  logic [sel_w-1:0]    ptr_q, ptr_d;
  logic                en, xfer;
  logic [width-1:0]    out_data_q;
  logic                out_valid_q, out_last_q;
  logic [sel_w-1:0]    out_sel_q;

  generate
    for (genvar gi = 0; gi < channels; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*width +: width];
    end
  endgenerate

  rr_arbiter #(.channels(channels)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // rst_n gates ready so nothing is offered while the block is held in reset.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = (en && rst_n) ? grant : '0;
  assign xfer     = |(in_ready & in_valid);
  assign ptr_inc  = (grant_idx == sel_w'(channels - 1)) ? '0 : grant_idx + 1'b1;

`ifdef STREAM_MUX_LOCK_EN
  state_e           state_q, state_d;
  logic [sel_w-1:0] lock_q, lock_d;

  always_comb begin
    grant     = arb_grant;
    grant_idx = arb_idx;
    state_d   = state_q;
    lock_d    = lock_q;
    ptr_d     = ptr_q;
    if (state_q == ST_LOCKED) begin
      grant         = '0;
      grant[lock_q] = 1'b1;
      grant_idx     = lock_q;
    end
    if (xfer) begin
      case (state_q)
        ST_IDLE: begin
          if (in_last[grant_idx]) begin
            ptr_d = ptr_inc;
          end else begin
            state_d = ST_LOCKED;
            lock_d  = grant_idx;
          end
        end
        ST_LOCKED: begin
          if (in_last[grant_idx]) begin
            state_d = ST_IDLE;
            ptr_d   = ptr_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end
`else
  always_comb begin
    grant     = arb_grant;
    grant_idx = arb_idx;
    ptr_d     = xfer ? ptr_inc : ptr_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ch_data[grant_idx];
        out_last_q  <= in_last[grant_idx];
        out_sel_q   <= grant_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: a 4x8 and a 3x16 instance run against a packet-level
// reference model; honours STREAM_MUX_LOCK_EN the same way the design does.
module tb_stream_mux;

  localparam int NA = 4, WA = 8, NB = 3, WB = 16;
`ifdef STREAM_MUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NA*WA-1:0] a_in_data;
  logic [NA-1:0]    a_in_valid, a_in_last, a_in_ready;
  logic [WA-1:0]    a_out_data;
  logic             a_out_valid, a_out_last, a_out_ready;
  logic [1:0]       a_out_sel;

  logic [NB*WB-1:0] b_in_data;
  logic [NB-1:0]    b_in_valid, b_in_last, b_in_ready;
  logic [WB-1:0]    b_out_data;
  logic             b_out_valid, b_out_last, b_out_ready;
  logic [1:0]       b_out_sel;

  stream_mux #(.width(WA), .channels(NA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_last(a_in_last), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_last(a_out_last), .out_sel(a_out_sel),
    .out_ready(a_out_ready)
  );

  stream_mux #(.width(WB), .channels(NB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_last(b_out_last), .out_sel(b_out_sel),
    .out_ready(b_out_ready)
  );

  typedef struct {
    int          ptr;
    bit          locked;
    int          lock_ch;
    bit          ov;
    logic [15:0] od;
    bit          ol;
    int          os;
  } mstate_t;

  mstate_t     ma, mb;
  logic [15:0] sa_vld, sa_lst, sb_vld, sb_lst;
  logic [15:0] sa_dat [16];
  logic [15:0] sb_dat [16];
  bit          sa_rdy, sb_rdy;
  int          n_chk = 0, n_fail = 0;
  int          xa = -1;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.ptr = 0; s.locked = 0; s.lock_ch = 0; s.ov = 0; s.od = '0; s.ol = 0; s.os = 0;
    return s;
  endfunction

  // Channel the arbitration rules pick this cycle, or -1 for none.
  function automatic int m_grant(mstate_t s, int n, logic [15:0] vld);
    if (LOCK && s.locked) return s.lock_ch;
    for (int k = 0; k < n; k++) begin
      if (vld[(s.ptr + k) % n]) return (s.ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_ready(mstate_t s, int n, logic [15:0] vld, bit ordy);
    int g;
    g = m_grant(s, n, vld);
    if ((!s.ov || ordy) && g >= 0) return 16'(1 << g);
    return 16'h0;
  endfunction

  function automatic mstate_t m_step(mstate_t s, int n, logic [15:0] vld, logic [15:0] lst,
                                     logic [15:0] dat [16], bit ordy, output int xch);
    int g;
    g   = m_grant(s, n, vld);
    xch = -1;
    if ((!s.ov || ordy) && g >= 0 && vld[g]) begin
      xch  = g;
      s.ov = 1; s.od = dat[g]; s.ol = lst[g]; s.os = g;
      if (!LOCK) s.ptr = (g + 1) % n;
      else if (s.locked) begin
        if (lst[g]) begin s.locked = 0; s.ptr = (s.lock_ch + 1) % n; end
      end else if (lst[g]) s.ptr = (g + 1) % n;
      else begin s.locked = 1; s.lock_ch = g; end
    end else if (s.ov && ordy) begin
      s.ov = 0;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NA; c++) a_in_data[c*WA +: WA] = sa_dat[c][WA-1:0];
    for (int c = 0; c < NB; c++) b_in_data[c*WB +: WB] = sb_dat[c];
    a_in_valid = sa_vld[NA-1:0]; a_in_last = sa_lst[NA-1:0]; a_out_ready = sa_rdy;
    b_in_valid = sb_vld[NB-1:0]; b_in_last = sb_lst[NB-1:0]; b_out_ready = sb_rdy;
  endtask

  // Called at a falling edge: drive, check, advance the model, wait for the next falling edge.
  task automatic tick();
    int xb;
    drive();
    #1;
    check("a_in_ready", 32'(a_in_ready), 32'(m_ready(ma, NA, sa_vld, sa_rdy)));
    check("a_out_valid", 32'(a_out_valid), 32'(ma.ov));
    if (ma.ov) begin
      check("a_out_data", 32'(a_out_data), 32'(ma.od[WA-1:0]));
      check("a_out_last", 32'(a_out_last), 32'(ma.ol));
      check("a_out_sel", 32'(a_out_sel), 32'(ma.os));
    end
    check("b_in_ready", 32'(b_in_ready), 32'(m_ready(mb, NB, sb_vld, sb_rdy)));
    check("b_out_valid", 32'(b_out_valid), 32'(mb.ov));
    if (mb.ov) begin
      check("b_out_data", 32'(b_out_data), 32'(mb.od));
      check("b_out_last", 32'(b_out_last), 32'(mb.ol));
      check("b_out_sel", 32'(b_out_sel), 32'(mb.os));
      check("b_sel_range", 32'(b_out_sel < 2'd3), 32'd1);
    end
    ma = m_step(ma, NA, sa_vld, sa_lst, sa_dat, sa_rdy, xa);
    mb = m_step(mb, NB, sb_vld, sb_lst, sb_dat, sb_rdy, xb);
    if (xa >= 0) $display("a: ch%0d beat 0x%02h last=%0d", xa, sa_dat[xa][7:0], sa_lst[xa]);
    if (xb >= 0) $display("b: ch%0d beat 0x%04h last=%0d", xb, sb_dat[xb], sb_lst[xb]);
    @(negedge clk);
  endtask

  // Assert reset at the current falling edge, check reset state, release at the next one.
  task automatic do_reset();
    drive();
    rst_n = 1'b0;
    #1;
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_a_out_data", 32'(a_out_data), 32'd0);
    check("rst_a_out_last", 32'(a_out_last), 32'd0);
    check("rst_a_out_sel", 32'(a_out_sel), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd0);
    ma = m_reset();
    mb = m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int beat, c0, c1;
    sa_vld = '0; sa_lst = '0; sb_vld = '0; sb_lst = '0; sa_rdy = 1; sb_rdy = 1;
    for (int c = 0; c < 16; c++) begin sa_dat[c] = '0; sb_dat[c] = '0; end
    ma = m_reset();
    mb = m_reset();
    @(negedge clk);

    // Reset with every channel valid, then single-beat rotation on both instances.
    sa_vld = 16'hF; sa_lst = 16'hF; sb_vld = 16'h7; sb_lst = 16'h7;
    for (int c = 0; c < 16; c++) begin sa_dat[c] = 16'(16'h10 + c); sb_dat[c] = 16'(16'h1000 + c); end
    do_reset();
    repeat (9) tick();

    // ch1 three-beat packet while ch2 is also valid.
    sb_vld = '0; sa_vld = 16'h2; sa_lst = 16'h4; sa_dat[2] = 16'h00C2; beat = 0;
    for (int t = 0; t < 20 && beat < 3; t++) begin
      sa_dat[1] = 16'(16'hA1 + beat);
      sa_lst[1] = (beat == 2);
      tick();
      if (xa == 1) beat++;
      sa_vld = 16'h6;
    end
    check("pkt_beats", 32'(beat), 32'd3);
    repeat (2) tick();
    sa_vld = '0;
    repeat (2) tick();

    // Backpressure: hold 0x5C for five stalled cycles.
    sa_vld = 16'h1; sa_lst = 16'h1; sa_dat[0] = 16'h005C;
    tick();
    sa_vld = 16'hF; sa_lst = 16'hF; sa_rdy = 0;
    for (int c = 0; c < NA; c++) sa_dat[c] = 16'(16'h60 + c);
    repeat (5) begin
      tick();
      check("bp_hold_data", 32'(a_out_data), 32'h5C);
      check("bp_ready_low", 32'(a_in_ready), 32'd0);
    end
    sa_rdy = 1;
    repeat (6) tick();

    // Randomised traffic, backpressure and packet boundaries.
    repeat (300) begin
      sa_vld = 16'($urandom); sa_lst = 16'($urandom | $urandom); sa_rdy = ($urandom_range(0, 3) != 0);
      sb_vld = 16'($urandom); sb_lst = 16'($urandom | $urandom); sb_rdy = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 16; c++) begin sa_dat[c] = 16'($urandom); sb_dat[c] = 16'($urandom); end
      tick();
    end

    // Reset in the middle of a ch2 packet.
    sa_vld = '0; sb_vld = '0; sa_rdy = 1; sb_rdy = 1;
    repeat (3) tick();
    sa_vld = 16'h4; sa_lst = 16'h0;
    repeat (2) tick();
    sa_vld = 16'hF; sa_lst = 16'hF;
    do_reset();
    tick();
    #1;
    check("post_rst_valid", 32'(a_out_valid), 32'd1);
    check("post_rst_sel", 32'(a_out_sel), 32'd0);
    tick();
    sa_vld = '0;
    repeat (2) tick();

    // ch0 and ch1 each send three-beat packets concurrently.
    sa_vld = 16'h3; c0 = 0; c1 = 0;
    for (int t = 0; t < 30 && (c0 < 6 || c1 < 6); t++) begin
      sa_lst[0] = (c0 % 3 == 2); sa_lst[1] = (c1 % 3 == 2);
      sa_dat[0] = 16'(16'h30 + c0); sa_dat[1] = 16'(16'h40 + c1);
      tick();
      if (xa == 0) c0++;
      if (xa == 1) c1++;
    end
    check("pkt_pair_beats", 32'(c0 + c1), 32'd12);
    sa_vld = '0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
